// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions used by csr and trap_ctrl.
package csr_pkg;

  localparam int XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_EBREAK  = 4'd3;
  localparam logic [3:0] EXC_ECALL_M = 4'd11;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_MEPC   = 3'd1,
    ST_W_MCAUSE = 3'd2,
    ST_W_MTVAL  = 3'd3,
    ST_REDIRECT = 3'd4,
    ST_MRET     = 3'd5
  } trap_state_t;

endpackage

// File: rtl/irq_arb.sv
// Fixed-priority machine interrupt selector: MEI > MSI > MTI.
module irq_arb
  import csr_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [2:0] enable,
  output logic       take,
  output logic [3:0] code
);

  logic [2:0] active;

  assign active = pending & enable;
  assign take   = |active;

  always_comb begin
    code = 4'd0;
    if (active[2])      code = IRQ_MEI;
    else if (active[1]) code = IRQ_MSI;
    else if (active[0]) code = IRQ_MTI;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/mtval, toggles mstatus.MIE
// and issues a one-cycle fetch redirect for traps and mret.
module trap_ctrl
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [63:0] exc_pc,
  input  logic [63:0] exc_tval,
  input  logic        mret_valid,
  input  logic [63:0] irq_pc,
  input  logic        wb_boundary,
  input  logic [2:0]  irq_pending,
  input  logic [2:0]  irq_enable,
  input  logic        mstatus_ie,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata,
  output logic        mstatus_ie_clear,
  output logic        mstatus_ie_set,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy
);

  trap_state_t state, state_next;

  logic        irq_take;
  logic [3:0]  irq_code;
  logic        irq_ok;

  logic [63:0] epc_q;
  logic [63:0] tval_q;
  logic [3:0]  code_q;
  logic        is_irq_q;

  logic [63:0] mcause_w;
  logic [63:0] tvec_base;
  logic        unused_mepc_lsb;

  irq_arb u_irq_arb (
    .pending (irq_pending),
    .enable  (irq_enable),
    .take    (irq_take),
    .code    (irq_code)
  );

  assign irq_ok          = mstatus_ie & wb_boundary & irq_take;
  assign mcause_w        = {is_irq_q, 59'd0, code_q};
  assign tvec_base       = {mtvec[63:2], 2'b00};
  assign unused_mepc_lsb = ^mepc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Trap context is captured only at acceptance; an mret leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q    <= '0;
      tval_q   <= '0;
      code_q   <= '0;
      is_irq_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (exc_valid) begin
        epc_q    <= exc_pc;
        tval_q   <= exc_tval;
        code_q   <= exc_cause;
        is_irq_q <= 1'b0;
      end else if (!mret_valid && irq_ok) begin
        epc_q    <= irq_pc;
        tval_q   <= '0;
        code_q   <= irq_code;
        is_irq_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (exc_valid)       state_next = ST_W_MEPC;
        else if (mret_valid) state_next = ST_MRET;
        else if (irq_ok)     state_next = ST_W_MEPC;
      end
      ST_W_MEPC:   state_next = ST_W_MCAUSE;
      ST_W_MCAUSE: state_next = ST_W_MTVAL;
      ST_W_MTVAL:  state_next = ST_REDIRECT;
      ST_REDIRECT: state_next = ST_IDLE;
      ST_MRET:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_we           = 1'b0;
    csr_waddr        = 12'd0;
    csr_wdata        = 64'd0;
    mstatus_ie_clear = 1'b0;
    mstatus_ie_set   = 1'b0;
    flush            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 64'd0;
    busy             = (state != ST_IDLE);
    unique case (state)
      ST_W_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = epc_q;
        flush     = 1'b1;
      end
      ST_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = mcause_w;
      end
      ST_W_MTVAL: begin
        csr_we           = 1'b1;
        csr_waddr        = CSR_MTVAL;
        csr_wdata        = tval_q;
        mstatus_ie_clear = 1'b1;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        // Only interrupts vector; mode 2/3 falls back to direct.
        if (is_irq_q && (mtvec[1:0] == 2'd1))
          redirect_pc = tvec_base + {58'd0, code_q, 2'b00};
        else
          redirect_pc = tvec_base;
      end
      ST_MRET: begin
        mstatus_ie_set = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = {mepc[63:2], 2'b00};
        flush          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
